iter_muldiv_alu: RTL and testbench



---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/iter_muldiv_alu.sv | 179 +++++++++++++++++
 tb/tb_iter_muldiv_alu.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, flag indices.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'b000,
    OP_MULH  = 3'b001,
    OP_MULHU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_REM   = 3'b101,
    OP_REMU  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // True for the four quotient/remainder ops.
  function automatic logic is_div_op(input logic [2:0] o);
    return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide trial subtract.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   prod,
  input  logic [XLEN-1:0]     rem,
  input  logic [XLEN-1:0]     quo,
  input  logic [XLEN-1:0]     mag_b,
  output logic [2*XLEN-1:0]   prod_next,
  output logic [XLEN-1:0]     rem_next,
  output logic [XLEN-1:0]     quo_next
);

  logic [XLEN:0] acc;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Multiplier bits sit in the low half of prod and are consumed LSB first; the carry out of
  // the upper-half add is kept in acc[XLEN] and shifted back in. Divide shifts the next
  // dividend bit (quo MSB) into the remainder and keeps the trial only if it did not borrow.
  always_comb begin
    prod_next = prod;
    rem_next  = rem;
    quo_next  = quo;
    acc       = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_b} : '0);
    shifted   = {rem, quo[XLEN-1]};
    trial     = shifted - {1'b0, mag_b};
    if (is_div) begin
      if (!trial[XLEN]) begin
        rem_next = trial[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
      end
    end else begin
      prod_next = {acc, prod[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv_alu.sv
// Iterative RV32M multiply/divide unit: operands are reduced to magnitudes on accept, run
// through XLEN radix-2 steps, then sign-corrected. Special cases finish without iterating.
module iter_muldiv_alu
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      flags
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [2*XLEN-1:0] prod;
  logic              neg;

  logic [2*XLEN-1:0] prod_next;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_next;

  logic              signed_op, a_neg, b_neg, acc_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic              spec_c, spec_v;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  logic              fix_v;

  function automatic logic [3:0] pack_flags(input logic [XLEN-1:0] r, input logic c,
                                            input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[XLEN-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign in_ready  = (state == StIdle);
  assign out_valid = (state == StDone);

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div    (is_div_op(op_q)),
    .prod      (prod),
    .rem       (rem),
    .quo       (quo),
    .mag_b     (mag_b),
    .prod_next (prod_next),
    .rem_next  (rem_next),
    .quo_next  (quo_next)
  );

  // Accept-time decode: magnitudes, result sign and the short-circuit special cases.
  // MUL is treated as signed so the full product is available for the overflow flag.
  always_comb begin
    signed_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
    div_zero  = is_div_op(op) && (b == '0);
    div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_VAL) && (b == '1);
    special   = div_zero || div_ovf || (op == OP_RSVD);
    spec_res  = '0;
    spec_c    = 1'b0;
    spec_v    = 1'b0;
    if (op == OP_RSVD) begin
      spec_res = '0;
    end else if (div_zero) begin
      spec_c   = 1'b1;
      spec_res = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    end else if (div_ovf) begin
      spec_v   = 1'b1;
      spec_res = (op == OP_DIV) ? MIN_VAL : '0;
    end
    case (op)
      OP_MUL, OP_MULH, OP_DIV: acc_neg = a_neg ^ b_neg;
      OP_REM:                  acc_neg = a_neg;
      default:                 acc_neg = 1'b0;
    endcase
  end

  // Sign correction and half/quotient/remainder selection once iteration is complete.
  always_comb begin
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -quo : quo;
    rem_fix  = neg ? -rem : rem;
    fix_v    = 1'b0;
    case (op_q)
      OP_MUL: begin
        fix_res = prod_fix[XLEN-1:0];
        fix_v   = (prod_fix[2*XLEN-1:XLEN] != {XLEN{prod_fix[XLEN-1]}});
      end
      OP_MULH, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   fix_res = quo_fix;
      OP_REM, OP_REMU:   fix_res = rem_fix;
      default:           fix_res = '0;
    endcase
  end

  // Control FSM with the iteration datapath registers and registered result/flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= StIdle;
      op_q   <= '0;
      cnt    <= '0;
      mag_b  <= '0;
      rem    <= '0;
      quo    <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            op_q  <= op;
            mag_b <= abs_b;
            neg   <= acc_neg;
            prod  <= {{XLEN{1'b0}}, abs_a};
            rem   <= '0;
            quo   <= abs_a;
            if (special) begin
              result <= spec_res;
              flags  <= pack_flags(spec_res, spec_c, spec_v);
              state  <= StDone;
            end else begin
              cnt   <= CNT_W'(XLEN - 1);
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          prod <= prod_next;
          rem  <= rem_next;
          quo  <= quo_next;
          if (cnt == '0) begin
            state <= StFix;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StFix: begin
          result <= fix_res;
          flags  <= pack_flags(fix_res, 1'b0, fix_v);
          state  <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Directed bench for iter_muldiv_alu with a plain-arithmetic reference model checked every
// cycle the output is valid, plus literal expectations from hand-worked vectors.
module tb_iter_muldiv_alu;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [3:0]      flags;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res;
  logic [3:0]  exp_flg;
  logic        exp_live = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  iter_muldiv_alu #(
    .XLEN (XLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Reference: RISC-V M semantics from 64-bit integer arithmetic.
  function automatic void model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] r, output logic [3:0] f);
    longint          sp;
    longint unsigned up;
    logic [63:0]     p;
    logic            c;
    logic            v;
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    sp = longint'($signed(ma)) * longint'($signed(mb));
    up = 64'(ma) * 64'(mb);
    case (mop)
      3'd0: begin
        p = sp;
        r = p[31:0];
        v = (sp != longint'($signed(p[31:0])));
      end
      3'd1: begin
        p = sp;
        r = p[63:32];
      end
      3'd2: begin
        p = up;
        r = p[63:32];
      end
      3'd3: begin
        if (mb == '0) begin
          r = '1;
          c = 1'b1;
        end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          r = ma;
          v = 1'b1;
        end else begin
          r = $signed(ma) / $signed(mb);
        end
      end
      3'd4: begin
        if (mb == '0) begin
          r = '1;
          c = 1'b1;
        end else begin
          r = ma / mb;
        end
      end
      3'd5: begin
        if (mb == '0) begin
          r = ma;
          c = 1'b1;
        end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          r = '0;
          v = 1'b1;
        end else begin
          r = $signed(ma) % $signed(mb);
        end
      end
      3'd6: begin
        if (mb == '0) begin
          r = ma;
          c = 1'b1;
        end else begin
          r = ma % mb;
        end
      end
      default: r = '0;
    endcase
    f = {r[31], (r == '0), c, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every cycle with out_valid high must match the model's answer for the op in flight.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!reset && out_valid) begin
        checks++;
        if (!exp_live || result !== exp_res || flags !== exp_flg) begin
          failures++;
          $display("FAIL model_cmp live=%0b result=%h flags=%b required result=%h flags=%b",
                   exp_live, result, flags, exp_res, exp_flg);
        end
      end
    end
  endtask

  // Latency counts posedges with the accepting edge as 1: a normal op shows out_valid after
  // edge XLEN+2, a special case right after the accepting edge.
  task automatic run_op(input string tag, input vec_t v, input int hold);
    int          lat;
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    op       = v.op;
    a        = v.a;
    b        = v.b;
    in_valid = 1'b1;
    model(v.op, v.a, v.b, exp_res, exp_flg);
    exp_live = 1'b1;
    chk({tag, "_model_res"}, 64'(exp_res), 64'(v.res));
    chk({tag, "_model_flg"}, 64'(exp_flg), 64'(v.flg));
    @(posedge clk);
    #1;
    // Keep in_valid high with junk while busy: it must be ignored and inputs not resampled.
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
    chk({tag, "_result"}, 64'(result), 64'(v.res));
    chk({tag, "_flags"}, 64'(flags), 64'(v.flg));
    held_res = result;
    held_flg = flags;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_hold_stable"}, {28'd0, held_flg, held_res}, {28'd0, flags, result});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_live  = 1'b0;
    chk({tag, "_released_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_released_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;

    vecs.push_back('{OP_MUL,   32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b1000, 34});
    vecs.push_back('{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000, 34});
    vecs.push_back('{OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 34});
    vecs.push_back('{OP_DIV,   32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, 4'b1000, 34});
    vecs.push_back('{OP_REM,   32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 4'b1000, 34});
    vecs.push_back('{OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1010, 1});
    vecs.push_back('{OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0101, 1});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, 1});
    vecs.push_back('{OP_REMU,  32'd5,         32'd0,         32'd5,         4'b0010, 1});
    vecs.push_back('{OP_REM,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 4'b1010, 1});
    vecs.push_back('{OP_RSVD,  32'd1,         32'd2,         32'd0,         4'b0100, 1});
    vecs.push_back('{OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0,         4'b0101, 34});
    vecs.push_back('{OP_MUL,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, 34});
    vecs.push_back('{OP_MUL,   32'h1234_5678, 32'd0,         32'd0,         4'b0100, 34});
    vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd14,        4'b0000, 34});
    vecs.push_back('{OP_REMU,  32'd100,       32'd7,         32'd2,         4'b0000, 34});
    vecs.push_back('{OP_MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 4'b1000, 34});
    vecs.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 4'b1000, 34});
    vecs.push_back('{OP_REM,   32'd7,         32'hFFFF_FFFE, 32'd1,         4'b0000, 34});

    fork
      compare_loop();
    join_none

    @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'(flags), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First vector is held 10 cycles before release; the next op follows immediately.
    foreach (vecs[i]) begin
      run_op($sformatf("v%0d", i), vecs[i], (i == 0) ? 10 : 0);
    end

    // Abort a DIV in its 10th CALC cycle.
    op       = OP_DIV;
    a        = 32'd1000;
    b        = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rv = '{OP_MUL, 32'd3, 32'd4, 32'd12, 4'b0000, 34};
    run_op("after_abort", rv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
